regfile_mp: RTL and testbench

Parametrised integer register file for the RISC-V core, the successor to the single-issue register file. It provides NREAD combinational read ports, one writeback port and one dedicated JAL link port that writes pc+4. All writes are clocked. A sequencer clears the whole array after reset. A per-register pending scoreboard feeds hazard detection. It sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

---
 rtl/riscv_pkg.sv | 11 +
 rtl/rf_scoreboard.sv | 47 ++++
 rtl/regfile_mp.sv | 95 +++++++++
 tb/tb_regfile_mp.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and types for the RISC-V core register file
package riscv_pkg;
    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int LINK_OFFSET   = 4;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } regfile_state_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits with set-over-clear priority
import riscv_pkg::*;

module rf_scoreboard #(
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [AW-1:0]         set_addr,
    input  logic                  clr0_en,
    input  logic [AW-1:0]         clr0_addr,
    input  logic                  clr1_en,
    input  logic [AW-1:0]         clr1_addr,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD-1:0]      rd_pending
);
    logic [NREGS-1:0] r_pending;

    // A set in the same cycle as a clear means a newer producer was issued, so set wins
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (set_en && set_addr == AW'(r))
                    r_pending[r] <= 1'b1;
                else if ((clr0_en && clr0_addr == AW'(r)) || (clr1_en && clr1_addr == AW'(r)))
                    r_pending[r] <= 1'b0;
            end
            r_pending[0] <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [AW-1:0] w_a;
        logic          w_clr;
        logic          w_set;
        assign w_a   = rd_addr[gi*AW +: AW];
        assign w_clr = (clr0_en && clr0_addr == w_a) || (clr1_en && clr1_addr == w_a);
        assign w_set = set_en && set_addr == w_a;
        assign rd_pending[gi] = r_pending[w_a] & ~((BYPASS != 0) && w_clr && !w_set);
    end
endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read register file with link port, clear sequencer and scoreboard
import riscv_pkg::*;

module regfile_mp #(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_pending,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  link_en,
    input  logic [AW-1:0]         link_addr,
    input  logic [XLEN-1:0]       link_pc,
    input  logic                  sb_set_en,
    input  logic [AW-1:0]         sb_set_addr,
    output logic                  init_busy
);
    regfile_state_t   r_state;
    logic [AW-1:0]    r_cnt;
    logic [XLEN-1:0]  r_regs [NREGS];

    logic             w_run;
    logic             w_wr_ok;
    logic             w_link_ok;
    logic [XLEN-1:0]  w_link_val;
    logic [NREAD-1:0] w_sb_pending;

    assign w_run      = (r_state == RF_RUN);
    assign w_wr_ok    = w_run && wr_en && (wr_addr != '0);
    assign w_link_ok  = w_run && link_en && (link_addr != '0);
    assign w_link_val = link_pc + XLEN'(LINK_OFFSET);
    assign init_busy  = !w_run;

    // The link write is issued after the writeback write so it wins on a collision
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RF_INIT;
            r_cnt   <= AW'(1);
        end else if (r_state == RF_INIT) begin
            r_regs[r_cnt] <= '0;
            r_cnt         <= r_cnt + AW'(1);
            if (r_cnt == AW'(NREGS - 1))
                r_state <= RF_RUN;
        end else begin
            if (w_wr_ok)
                r_regs[wr_addr] <= wr_data;
            if (w_link_ok)
                r_regs[link_addr] <= w_link_val;
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [AW-1:0]   w_a;
        logic [XLEN-1:0] w_val;
        assign w_a = rd_addr[gi*AW +: AW];
        always_comb begin
            w_val = r_regs[w_a];
            if (!w_run || w_a == '0)
                w_val = '0;
            else if (BYPASS != 0 && w_link_ok && link_addr == w_a)
                w_val = w_link_val;
            else if (BYPASS != 0 && w_wr_ok && wr_addr == w_a)
                w_val = wr_data;
        end
        assign rd_data[gi*XLEN +: XLEN] = w_val;
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .BYPASS (BYPASS),
        .AW     (AW)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .set_en     (w_run && sb_set_en),
        .set_addr   (sb_set_addr),
        .clr0_en    (w_run && wr_en),
        .clr0_addr  (wr_addr),
        .clr1_en    (w_run && link_en),
        .clr1_addr  (link_addr),
        .rd_addr    (rd_addr),
        .rd_pending (w_sb_pending)
    );

    assign rd_pending = w_sb_pending & {NREAD{w_run}};
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed vector bench for regfile_mp with and without bypass
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_pending_b, rd_pending_n;
    logic        wr_en, link_en, sb_set_en;
    logic [4:0]  wr_addr, link_addr, sb_set_addr;
    logic [31:0] wr_data, link_pc;
    logic        init_busy_b, init_busy_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_pending(rd_pending_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .link_en(link_en), .link_addr(link_addr), .link_pc(link_pc),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .init_busy(init_busy_b)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_pending(rd_pending_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .link_en(link_en), .link_addr(link_addr), .link_pc(link_pc),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .init_busy(init_busy_n)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        le;
        logic [4:0]  la;
        logic [31:0] lpc;
        logic        se;
        logic [4:0]  sa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d0n;
        logic [31:0] d1;
        logic        p0;
        logic        p1;
        logic        p0n;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        link_en = 1'b0; link_addr = '0; link_pc = '0;
        sb_set_en = 1'b0; sb_set_addr = '0;
    endtask

    task automatic count_init(input string name);
        int n = 0;
        while (init_busy_b && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk(name, 32'(n), 32'd31);
        chk({name, "_nb_done"}, {31'd0, init_busy_n}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 32'h100, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h100, 1'b0, 5'd0, 5'd1, 5'd5, 32'h104, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'hFFFFFFFE, 1'b0, 5'd0, 5'd1, 5'd5, 32'h2, 32'h104, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd5, 32'h2, 32'h2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd7, 32'h200, 1'b0, 5'd0, 5'd7, 5'd7, 32'h204, 32'h0, 32'h204, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h204, 32'h204, 32'h204, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 5'd9, 32'h11111111, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h11111111, 32'h0, 32'h11111111, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h11111111, 32'h11111111, 32'h11111111, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 5'd9, 32'h22222222, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h22222222, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h22222222, 32'h22222222, 32'h22222222, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h10, 1'b0, 5'd0, 5'd3, 5'd4, 32'h33, 32'h0, 32'h14, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4, 32'h33, 32'h33, 32'h14, 1'b0, 1'b0, 1'b0};

        // Reset, then try to disturb the array while the clear sequence runs
        idle_inputs();
        rd_addr = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy_byp", {31'd0, init_busy_b}, 32'd1);
        chk("reset_busy_nb", {31'd0, init_busy_n}, 32'd1);
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFFFFFF;
        link_en = 1'b1; link_addr = 5'd6; link_pc = 32'h40;
        sb_set_en = 1'b1; sb_set_addr = 5'd5;
        rd_addr = {5'd6, 5'd5};
        #1;
        chk("init_rd_forced0", rd_data_b[31:0], 32'h0);
        chk("init_pend_forced0", {30'd0, rd_pending_b}, 32'h0);
        count_init("init_len");
        idle_inputs();

        for (int r = 1; r < 32; r++) begin
            rd_addr = {5'd0, 5'(r)};
            #1;
            chk($sformatf("clear_x%0d_byp", r), rd_data_b[31:0], 32'h0);
            chk($sformatf("clear_x%0d_nb", r), rd_data_n[31:0], 32'h0);
        end
        rd_addr = {5'd6, 5'd5};
        #1;
        chk("init_sb_ignored", {30'd0, rd_pending_b}, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            link_en = vecs[i].le; link_addr = vecs[i].la; link_pc = vecs[i].lpc;
            sb_set_en = vecs[i].se; sb_set_addr = vecs[i].sa;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            #1;
            chk($sformatf("v%0d_d0", i), rd_data_b[31:0], vecs[i].d0);
            chk($sformatf("v%0d_d0_nb", i), rd_data_n[31:0], vecs[i].d0n);
            chk($sformatf("v%0d_d1", i), rd_data_b[63:32], vecs[i].d1);
            chk($sformatf("v%0d_p0", i), {31'd0, rd_pending_b[0]}, {31'd0, vecs[i].p0});
            chk($sformatf("v%0d_p1", i), {31'd0, rd_pending_b[1]}, {31'd0, vecs[i].p1});
            chk($sformatf("v%0d_p0_nb", i), {31'd0, rd_pending_n[0]}, {31'd0, vecs[i].p0n});
            @(posedge clk); #1;
        end
        idle_inputs();

        // Pending bit set before a reset must be gone afterwards; reset mid-clear restarts it
        sb_set_en = 1'b1; sb_set_addr = 5'd12;
        @(posedge clk); #1;
        idle_inputs();
        rd_addr = {5'd0, 5'd12};
        #1;
        chk("sb_x12_set", {31'd0, rd_pending_b[0]}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_init_busy", {31'd0, init_busy_b}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        count_init("restart_len");
        rd_addr = {5'd5, 5'd12};
        #1;
        chk("sb_x12_after_reset", {30'd0, rd_pending_b}, 32'd0);
        chk("x5_recleared", rd_data_b[63:32], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
